// File: rtl/usermem_arbiter.sv
// Round-robin arbiter sharing the single user-memory port between the CPU and the DMA master.
// Each grant runs one transaction of WAIT+1 access cycles, then a one-cycle done pulse.
module usermem_arbiter #(
  parameter int AW   = 8,
  parameter int DW   = 8,
  parameter int WAIT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_rw,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_done,
  input  logic          dma_req,
  input  logic          dma_rw,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_done,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic [AW-1:0] usermem_address,
  inout  wire  [DW-1:0] usermem_data,
  output logic          rw
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic       M_CPU    = 1'b0;
  localparam logic       M_DMA    = 1'b1;
  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          rw_q, rw_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          win;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= M_CPU;
      last_q  <= M_DMA;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b1;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rw_d    = rw_q;
    rdata_d = rdata_q;
    win     = M_CPU;
    case (state_q)
      IDLE: begin
        if (cpu_req || dma_req) begin
          // On a tie the master that did not win last time goes next.
          win     = (cpu_req && dma_req) ? ~last_q : dma_req;
          owner_d = win;
          last_d  = win;
          addr_d  = win ? dma_addr  : cpu_addr;
          wdata_d = win ? dma_wdata : cpu_wdata;
          rw_d    = win ? dma_rw    : cpu_rw;
          cnt_d   = WAIT_CNT;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (rw_q) rdata_d = usermem_data;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The bus is driven only during a write ACCESS; DONE and IDLE are turnaround cycles.
  assign usermem_data    = (state_q == ACCESS && !rw_q) ? wdata_q : {DW{1'bz}};
  assign usermem_address = addr_q;
  assign rw              = (state_q == ACCESS) ? rw_q : 1'b1;
  assign busy            = (state_q != IDLE);
  assign cpu_gnt         = busy && (owner_q == M_CPU);
  assign dma_gnt         = busy && (owner_q == M_DMA);
  assign cpu_done        = (state_q == DONE) && (owner_q == M_CPU);
  assign dma_done        = (state_q == DONE) && (owner_q == M_DMA);
  assign rdata           = rdata_q;

endmodule

// File: doc/usermem_arbiter.md
# usermem_arbiter

Shares the single user-memory port (8-bit address, bidirectional 8-bit data, `rw`) between the CPU control unit and a second bus master (DMA/I/O engine). It uses round-robin arbitration at transaction granularity and runs one transaction per grant. Each transaction takes a programmable number of wait states. The arbiter sits between the `control` block's user-memory signals and the external user memory.

## Interface
Parameters:
- `AW`, 8, address width
- `DW`, 8, data width
- `WAIT`, 1, extra access cycles per transaction (0..15)

Ports (clock and reset first):
- `clk`  input  1  single system clock; all state changes on rising edge
- `reset`  input  1  synchronous, active-high
- `cpu_req`  input  1  CPU requests a transaction; held until `cpu_done`
- `cpu_rw`  input  1  1 = read, 0 = write
- `cpu_addr`  input  AW  CPU address
- `cpu_wdata`  input  DW  CPU write data
- `cpu_gnt`  output  1  CPU owns the memory port
- `cpu_done`  output  1  one-cycle completion pulse to CPU
- `dma_req`, `dma_rw`, `dma_addr`, `dma_wdata`  inputs  1/1/AW/DW  same meaning for DMA master
- `dma_gnt`, `dma_done`  outputs  1/1  same meaning for DMA master
- `rdata`  output  DW  read data; valid while either `*_done` is high
- `busy`  output  1  state ≠ IDLE
- `usermem_address`  output  AW  memory address
- `usermem_data`  inout  DW  memory data bus
- `rw`  output  1  memory direction: 1 = read (memory drives bus), 0 = write

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **IDLE, no request:** stay.
- **IDLE, any request:**
  - Pick the winner, per the arbitration rule below.
  - Latch the winner's addr, wdata and rw, and set its gnt.
  - Load `cnt` = WAIT and go to ACCESS.
- **Arbitration:**
  - Only one requester → it wins.
  - Both requesting → the master not equal to `last` wins.
  - `last` updates to the winner at grant.
  - `last` resets to DMA, so the CPU wins the first tie.
- **ACCESS:**
  - `usermem_address` = latched addr; `rw` = latched rw.
  - `usermem_data` is driven with latched wdata only when the latched rw = 0; otherwise high-Z.
  - Each edge with `cnt` ≠ 0: decrement `cnt`.
  - Edge with `cnt` = 0: if read, capture `usermem_data` into `rdata`; go to DONE.
- **DONE:**
  - Winner's `*_done` = 1 for exactly one cycle; gnt stays high; bus released (high-Z, `rw` = 1).
  - Next edge → IDLE and gnt clears.
- **Requester rule:** the requester drops req during the DONE cycle, or keeps it high to request a new transaction. Req sampled high in IDLE is always a new transaction.
- **Input changes:** req inputs are sampled only in IDLE. Changes to addr, wdata or rw after grant are ignored.
- **Write data:** `rdata` holds its last captured value after a write transaction.
- **Fairness:** a master holding req continuously alternates with the other master; no master waits more than one transaction.
- **Reset (synchronous):** any state → IDLE, including mid-ACCESS; the aborted transaction produces no done. Reset values:
  - `usermem_address` = 0, `rw` = 1, `usermem_data` high-Z
  - all gnt/done = 0, `rdata` = 0, `busy` = 0
  - `cnt` = 0, `last` = DMA
- **Idle outputs:** `usermem_address` holds its last value (0 after reset); `rw` = 1.

## Timing
- Edge E0 samples req in IDLE; grant is visible after E0.
- ACCESS lasts WAIT+1 cycles; read data is captured at edge E0+WAIT+1.
- Done is high in the cycle after E0+WAIT+1; IDLE resumes after E0+WAIT+2.
- Per-transaction occupancy is WAIT+3 cycles, including the IDLE sample cycle.
- Back-to-back throughput for one master: 1 transaction per WAIT+3 cycles.
- Write bus drive is active only in ACCESS cycles; there is no overlap with memory drive (DONE and IDLE are turnaround cycles).
- Outputs are registered or decoded from registered state only; there is no combinational path from req to gnt.

## Test plan
- **Reset values:** assert reset for 2 cycles, including once mid-ACCESS → all outputs at reset values, `usermem_data` = Z, no done pulse, next request granted normally.
- **CPU read (WAIT=1):** CPU reads addr 0x3C while the memory model drives 0xA5 → `cpu_gnt` after E0, `rw` = 1 for 2 cycles, `cpu_done` pulse after E0+2 with `rdata` = 0xA5, `dma_gnt` never set.
- **DMA write (WAIT=1):** DMA writes 0x5A to addr 0x10 → `rw` = 0 and bus = 0x5A for exactly 2 cycles, memory location 0x10 = 0x5A, `dma_done` one cycle, bus Z otherwise.
- **Simultaneous requests from reset:** CPU and DMA request in the same cycle → CPU granted first, DMA second; completion order is CPU then DMA.
- **Continuous contention:** both masters hold req for 6 transactions → grants alternate C,D,C,D,C,D; each done pulse exactly 1 cycle; spacing WAIT+3 cycles.
- **WAIT=0 corner:** with WAIT=0, CPU write then immediate CPU read of the same address → read returns the written value; occupancy 3 cycles each; no bus contention cycle.
